// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, FSM state type and B-immediate decode for the fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    HOLD
  } fetch_state_t;

  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// rtl/fetch_predecode.sv - backward-taken/forward-not-taken predecode of a fetched word
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] imm;
  logic        unused_reg_fields;

  assign imm      = b_imm(instr_i);
  assign taken_o  = (instr_i[6:0] == OPC_BRANCH) && imm[31];
  assign target_o = pc_i + imm;

  // register and funct3 fields play no part in the prediction
  assign unused_reg_fields = ^instr_i[24:12];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem req/ack port, skid buffer and IF/ID register; FETCH_BTFN_PREDICT_EN enables static branch prediction
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall_IF,
  input  logic            Stall_ID,
  input  logic            Redirect_EX,
  input  logic [XLEN-1:0] RedirectPC_EX,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            Valid_ID,
  output logic [31:0]     Instr_ID,
  output logic [XLEN-1:0] PC_ID,
  output logic [XLEN-1:0] PCPlus4_ID,
  output logic            PredTaken_ID
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic            pend_q, pend_d;

  logic            skid_vld_q, skid_vld_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            skid_pred_q, skid_pred_d;

  logic            vld_id_q, vld_id_d;
  logic [31:0]     instr_id_q, instr_id_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d;
  logic [XLEN-1:0] pcp4_id_q, pcp4_id_d;
  logic            pred_id_q, pred_id_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            fetch_ack;
  logic            unused_redirect_lsbs;

  assign pc_plus4             = pc_q + XLEN'(4);
  assign redirect_pc          = {RedirectPC_EX[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^RedirectPC_EX[1:0];

`ifdef FETCH_BTFN_PREDICT_EN
  fetch_predecode u_predecode (
    .instr_i  (imem_rdata),
    .pc_i     (pc_q),
    .taken_o  (pred_taken),
    .target_o (pred_target)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;
`endif

  // A request that has been raised stays up until acked, whatever Stall_IF does
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      FETCH:   imem_req = pend_q || (!Stall_IF && !skid_vld_q);
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
    if (reset) imem_req = 1'b0;
  end

  assign fetch_ack = (state_q == FETCH) && imem_req && imem_ack;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    pend_d       = pend_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pred_d  = skid_pred_q;
    vld_id_d     = vld_id_q;
    instr_id_d   = instr_id_q;
    pc_id_d      = pc_id_q;
    pcp4_id_d    = pcp4_id_q;
    pred_id_d    = pred_id_q;

    case (state_q)
      FETCH: begin
        pend_d = imem_req && !imem_ack;
        if (fetch_ack) begin
          pc_d = pred_taken ? pred_target : pc_plus4;
          if (Stall_ID) begin
            skid_vld_d   = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            skid_pred_d  = pred_taken;
            state_d      = HOLD;
          end
        end
      end
      DROP: begin
        pend_d = 1'b0;
        if (imem_ack) state_d = FETCH;
      end
      HOLD: begin
        if (!Stall_ID) begin
          skid_vld_d = 1'b0;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (!Stall_ID) begin
      if (skid_vld_q) begin
        vld_id_d   = 1'b1;
        instr_id_d = skid_instr_q;
        pc_id_d    = skid_pc_q;
        pcp4_id_d  = skid_pc_q + XLEN'(4);
        pred_id_d  = skid_pred_q;
      end else if (fetch_ack) begin
        vld_id_d   = 1'b1;
        instr_id_d = imem_rdata;
        pc_id_d    = pc_q;
        pcp4_id_d  = pc_plus4;
        pred_id_d  = pred_taken;
      end else begin
        vld_id_d   = 1'b0;
        instr_id_d = NOP;
        pred_id_d  = 1'b0;
      end
    end

    // Redirect overrides stalls, acks and prediction; an unacked request must still drain
    if (Redirect_EX) begin
      pc_d       = redirect_pc;
      pend_d     = 1'b0;
      skid_vld_d = 1'b0;
      vld_id_d   = 1'b0;
      instr_id_d = NOP;
      pred_id_d  = 1'b0;
      if (state_q == FETCH && imem_req && !imem_ack) begin
        state_d     = DROP;
        drop_addr_d = pc_q;
      end else if (state_q == DROP && !imem_ack) begin
        state_d = DROP;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      pend_q       <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= NOP;
      skid_pc_q    <= '0;
      skid_pred_q  <= 1'b0;
      vld_id_q     <= 1'b0;
      instr_id_q   <= NOP;
      pc_id_q      <= '0;
      pcp4_id_q    <= XLEN'(4);
      pred_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      pend_q       <= pend_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_pred_q  <= skid_pred_d;
      vld_id_q     <= vld_id_d;
      instr_id_q   <= instr_id_d;
      pc_id_q      <= pc_id_d;
      pcp4_id_q    <= pcp4_id_d;
      pred_id_q    <= pred_id_d;
    end
  end

  assign Valid_ID     = vld_id_q;
  assign Instr_ID     = instr_id_q;
  assign PC_ID        = pc_id_q;
  assign PCPlus4_ID   = pcp4_id_q;
  assign PredTaken_ID = pred_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage with an instruction-stream reference model
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;
`ifdef FETCH_BTFN_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall_if, stall_id, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        valid_id, pred_id;
  logic [31:0] instr_id, pc_id, pcp4_id;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .Stall_IF      (stall_if),
    .Stall_ID      (stall_id),
    .Redirect_EX   (redirect),
    .RedirectPC_EX (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .Valid_ID      (valid_id),
    .Instr_ID      (instr_id),
    .PC_ID         (pc_id),
    .PCPlus4_ID    (pcp4_id),
    .PredTaken_ID  (pred_id)
  );

  // Program image: a beq with imm=-8 at 0x120, otherwise distinct addi-shaped words
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0120) return 32'hFE000CE3;
    return {a[26:2], 7'b0010011};
  endfunction

  // Memory: acks a request once it has waited cur_lat cycles (0 = same cycle)
  int lat_cfg = 0;
  int cur_lat = 0;
  int req_age = 0;

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = imem_req && (req_age >= cur_lat);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) begin
      req_age <= req_age + 1;
    end else begin
      req_age <= 0;
      cur_lat <= (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
    end
  end

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Reference: the delivered stream must follow program order from the last reset/redirect
  bit          p_init = 1'b0;
  logic        p_req, p_ack, p_reset, p_redirect, p_stall_id;
  logic [31:0] p_addr;
  logic        p_valid, p_pred;
  logic [31:0] p_instr, p_pc, p_pcp4;
  logic [31:0] exp_pc = RST_PC;

  task automatic monitor();
    logic [31:0] w;
    logic [31:0] imm;
    logic        taken;
    if (reset) begin
      chk_b("req_low_in_reset", imem_req, 1'b0);
    end else if (p_init && p_req && !p_ack && !p_reset) begin
      chk_b("req_held_until_ack", imem_req, 1'b1);
      chk_w("addr_held_until_ack", imem_addr, p_addr);
    end
    if (imem_req) chk_b("addr_word_aligned", |imem_addr[1:0], 1'b0);
    if (!valid_id) chk_w("nop_when_invalid", instr_id, NOP_W);
    if (p_init) begin
      if (p_reset) begin
        chk_b("rst_valid", valid_id, 1'b0);
        chk_w("rst_pc_id", pc_id, 32'h0);
        chk_w("rst_pcp4_id", pcp4_id, 32'h4);
        chk_b("rst_pred", pred_id, 1'b0);
      end else if (p_redirect) begin
        chk_b("bubble_after_redirect", valid_id, 1'b0);
      end else if (p_stall_id) begin
        chk_b("hold_valid", valid_id, p_valid);
        chk_w("hold_instr", instr_id, p_instr);
        chk_w("hold_pc", pc_id, p_pc);
        chk_w("hold_pcp4", pcp4_id, p_pcp4);
        chk_b("hold_pred", pred_id, p_pred);
      end else if (valid_id) begin
        w     = mem_word(exp_pc);
        imm   = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        taken = PRED && (w[6:0] == 7'b1100011) && w[31];
        chk_w("stream_pc", pc_id, exp_pc);
        chk_w("stream_instr", instr_id, w);
        chk_w("stream_pcp4", pcp4_id, exp_pc + 32'd4);
        chk_b("stream_pred", pred_id, taken);
        exp_pc = taken ? exp_pc + imm : exp_pc + 32'd4;
      end
    end
    if (reset) exp_pc = RST_PC;
    else if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    p_req      = imem_req;
    p_ack      = imem_ack;
    p_reset    = reset;
    p_redirect = redirect;
    p_stall_id = stall_id;
    p_addr     = imem_addr;
    p_valid    = valid_id;
    p_instr    = instr_id;
    p_pc       = pc_id;
    p_pcp4     = pcp4_id;
    p_pred     = pred_id;
    p_init     = 1'b1;
  endtask

  task automatic look();
    @(negedge clk);
    monitor();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      look();
      step();
    end
  endtask

  initial begin
    reset = 1'b1; stall_if = 1'b0; stall_id = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; lat_cfg = 0;
    step();
    run(2);
    look();
    chk_b("reset_req", imem_req, 1'b0);
    chk_b("reset_valid", valid_id, 1'b0);
    chk_w("reset_instr", instr_id, NOP_W);
    chk_w("reset_pcp4", pcp4_id, 32'h4);
    step();

    // zero-wait sequential fetch
    reset = 1'b0;
    look(); chk_b("seq_req", imem_req, 1'b1); chk_w("seq_addr0", imem_addr, 32'h100); step();
    look(); chk_w("seq_addr1", imem_addr, 32'h104); chk_b("seq_valid1", valid_id, 1'b1);
    chk_w("seq_pcid1", pc_id, 32'h100); step();
    lat_cfg = 1;
    look(); chk_w("seq_addr2", imem_addr, 32'h108); chk_w("seq_pcid2", pc_id, 32'h104); step();
    look(); chk_w("lat1_addr", imem_addr, 32'h10C); step();

    // both stalls for 3 cycles, ack lands on the first
    stall_if = 1'b1; stall_id = 1'b1;
    look(); chk_b("stall_req_pending", imem_req, 1'b1); step();
    look(); chk_b("stall_req_off1", imem_req, 1'b0); step();
    look(); chk_b("stall_req_off2", imem_req, 1'b0); step();
    stall_if = 1'b0; stall_id = 1'b0; lat_cfg = 0;
    look(); chk_b("hold_release_req", imem_req, 1'b0); step();
    look(); chk_b("skid_valid", valid_id, 1'b1); chk_w("skid_pc", pc_id, 32'h10C);
    chk_w("skid_instr", instr_id, mem_word(32'h10C)); chk_w("after_skid_addr", imem_addr, 32'h110); step();

    // redirect while a 3-cycle request is outstanding
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    look(); chk_w("r2_addr0", imem_addr, 32'h100); step();
    run(1);
    lat_cfg = 3;
    look(); chk_w("r2_addr2", imem_addr, 32'h108); step();
    look(); chk_w("slow_addr", imem_addr, 32'h10C); step();
    redirect = 1'b1; redirect_pc = 32'h202;
    run(1);
    redirect = 1'b0;
    look(); chk_b("drop_req", imem_req, 1'b1); chk_w("drop_addr", imem_addr, 32'h10C);
    chk_b("drop_valid", valid_id, 1'b0); step();
    lat_cfg = 0;
    look(); chk_w("drop_addr_ack", imem_addr, 32'h10C); chk_b("drop_valid2", valid_id, 1'b0); step();
    look(); chk_w("target_addr", imem_addr, 32'h200); chk_b("no_wrong_path", valid_id, 1'b0); step();

    // redirect coincident with ack and Stall_ID
    redirect = 1'b1; redirect_pc = 32'h200; stall_id = 1'b1;
    look(); chk_w("target_pcid", pc_id, 32'h200); chk_w("coin_addr", imem_addr, 32'h204); step();
    redirect = 1'b0; stall_id = 1'b0;
    look(); chk_b("coin_valid", valid_id, 1'b0); chk_w("coin_next_addr", imem_addr, 32'h200); step();

    // backward branch at 0x120
    redirect = 1'b1; redirect_pc = 32'h120;
    look(); chk_w("coin_refetch_pc", pc_id, 32'h200); step();
    redirect = 1'b0;
    look(); chk_w("br_addr", imem_addr, 32'h120); step();
    lat_cfg = 3;
    look(); chk_w("br_pcid", pc_id, 32'h120); chk_b("br_pred", pred_id, PRED);
    chk_w("br_next_addr", imem_addr, PRED ? 32'h118 : 32'h124); step();

    // reset while in DROP
    redirect = 1'b1; redirect_pc = 32'h300;
    look(); chk_b("pre_drop_req", imem_req, 1'b1); step();
    redirect = 1'b0; reset = 1'b1;
    look(); chk_b("drop_reset_req", imem_req, 1'b0); step();
    lat_cfg = 0;
    look(); chk_b("drop_reset_req2", imem_req, 1'b0); step();
    reset = 1'b0;
    look(); chk_b("post_reset_req", imem_req, 1'b1); chk_w("post_reset_addr", imem_addr, RST_PC); step();

    // randomized traffic against the stream model
    lat_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      stall_if    = ($urandom_range(0, 3) == 0);
      stall_id    = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 32'h100 + ($urandom_range(0, 127) << 2) + $urandom_range(0, 3);
      reset       = ($urandom_range(0, 199) == 0);
      look();
      step();
    end
    stall_if = 1'b0; stall_id = 1'b0; redirect = 1'b0; reset = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
